// File: rtl/if_stage.sv
`timescale 1ns/1ps
// Instruction fetch: owns the PC, issues one imem request at a time, and feeds the IF/ID register.
// Latency: request to IF/ID load is memory latency + 1 edge; peak one instruction per 2 cycles.
// Backpressure: stall_i freezes IF/ID; a response that arrives while stalled is parked until the stall drops.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_valid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        if_id_valid_o,
    output logic [31:0] if_id_pc_o,
    output logic [31:0] if_id_inst_o
);

    // KILL means a request is still in flight whose response must be thrown away.
    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2,
        ST_KILL = 2'd3
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] hold_q;
    logic [31:0] hold_d;
    logic        load;
    logic [31:0] load_inst;

    logic        id_valid_q;
    logic [31:0] id_pc_q;
    logic [31:0] id_inst_q;

    // The request is masked during reset so the memory never sees a fetch from stale state.
    assign imem_req_o    = (state_q == ST_REQ) && !rst_i;
    assign imem_addr_o   = pc_q;
    assign if_id_valid_o = id_valid_q;
    assign if_id_pc_o    = id_pc_q;
    assign if_id_inst_o  = id_inst_q;

    // Next-state, next-PC and IF/ID load decision; a redirect overrides all of it.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        hold_d    = hold_q;
        load      = 1'b0;
        load_inst = imem_rdata_i;

        case (state_q)
            ST_REQ: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (imem_valid_i) begin
                    if (!stall_i) begin
                        load    = 1'b1;
                        pc_d    = pc_q + 32'd4;
                        state_d = ST_REQ;
                    end else begin
                        hold_d  = imem_rdata_i;
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (!stall_i) begin
                    load      = 1'b1;
                    load_inst = hold_q;
                    pc_d      = pc_q + 32'd4;
                    state_d   = ST_REQ;
                end
            end
            ST_KILL: begin
                if (imem_valid_i) begin
                    state_d = ST_REQ;
                end
            end
            default: begin
                state_d = ST_REQ;
            end
        endcase

        // Go straight back to REQ only when no response can still be in flight.
        if (redirect_i) begin
            load = 1'b0;
            pc_d = redirect_pc_i & 32'hFFFF_FFFC;
            if ((state_q == ST_HOLD) ||
                (imem_valid_i && ((state_q == ST_WAIT) || (state_q == ST_KILL)))) begin
                state_d = ST_REQ;
            end else begin
                state_d = ST_KILL;
            end
        end
    end

    // Fetch-side state: FSM, PC and the parked response word.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_REQ;
            pc_q    <= RESET_PC;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            hold_q  <= hold_d;
        end
    end

    // IF/ID register: flush on redirect, load a fetched word, hold on stall, otherwise bubble.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            id_valid_q <= 1'b0;
            id_pc_q    <= '0;
            id_inst_q  <= NOP_INST;
        end else if (redirect_i) begin
            id_valid_q <= 1'b0;
            id_inst_q  <= NOP_INST;
        end else if (load) begin
            id_valid_q <= 1'b1;
            id_pc_q    <= pc_q;
            id_inst_q  <= load_inst;
        end else if (!stall_i) begin
            id_valid_q <= 1'b0;
            id_inst_q  <= NOP_INST;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
`timescale 1ns/1ps
// Bench for if_stage: directed cycle script, scoreboarded fetch addresses and IF/ID loads.
// A second instance with a wrapping RESET_PC runs against its own 1-cycle memory.
// Memory model: captures a request at the falling edge, answers after a programmable latency.
module tb_if_stage;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ifid_t;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;

    logic        req_w;
    logic [31:0] addr_w;
    logic        valid_w;
    logic [31:0] rdata_w;
    logic        id_valid_w;
    logic [31:0] id_pc_w;
    logic [31:0] id_inst_w;

    int          n_chk;
    int          n_fail;
    int          lat;
    int          n_req_w;

    logic [31:0] exp_req[$];
    logic [31:0] exp_req_w[$];
    ifid_t       exp_ifid[$];

    if_stage u_dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .stall_i       (stall),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .imem_req_o    (imem_req),
        .imem_addr_o   (imem_addr),
        .imem_valid_i  (imem_valid),
        .imem_rdata_i  (imem_rdata),
        .if_id_valid_o (id_valid),
        .if_id_pc_o    (id_pc),
        .if_id_inst_o  (id_inst)
    );

    if_stage #(.RESET_PC(32'hFFFF_FFF8)) u_dut_w (
        .clk_i         (clk),
        .rst_i         (rst),
        .stall_i       (1'b0),
        .redirect_i    (1'b0),
        .redirect_pc_i (32'h0),
        .imem_req_o    (req_w),
        .imem_addr_o   (addr_w),
        .imem_valid_i  (valid_w),
        .imem_rdata_i  (rdata_w),
        .if_id_valid_o (id_valid_w),
        .if_id_pc_o    (id_pc_w),
        .if_id_inst_o  (id_inst_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic flag(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Main memory: one outstanding request, response = request address, latency from 'lat'.
    initial begin
        bit          pend;
        int          cnt;
        logic [31:0] maddr;
        pend       = 1'b0;
        cnt        = 0;
        maddr      = '0;
        imem_valid = 1'b0;
        imem_rdata = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pend = 1'b0;
            end else if (imem_req) begin
                pend  = 1'b1;
                cnt   = lat;
                maddr = imem_addr;
            end
            @(posedge clk);
            #1;
            imem_valid = 1'b0;
            if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    imem_valid = 1'b1;
                    imem_rdata = maddr;
                    pend       = 1'b0;
                end
            end
        end
    end

    // Memory for the wrap instance: fixed 1-cycle latency.
    initial begin
        bit          wreq;
        logic [31:0] waddr;
        valid_w = 1'b0;
        rdata_w = '0;
        forever begin
            @(negedge clk);
            wreq  = req_w && !rst;
            waddr = addr_w;
            @(posedge clk);
            #1;
            valid_w = wreq;
            rdata_w = waddr;
        end
    end

    // Monitor: compares every request and every fresh IF/ID load against the queues.
    initial begin
        bit    prev_stall;
        ifid_t e;
        prev_stall = 1'b0;
        forever begin
            @(negedge clk);
            if (imem_req) begin
                if (exp_req.size() == 0) flag("unexpected_req");
                else check("req_addr", imem_addr, exp_req.pop_front());
            end
            if (id_valid && !prev_stall) begin
                if (exp_ifid.size() == 0) begin
                    flag("unexpected_ifid_load");
                end else begin
                    e = exp_ifid.pop_front();
                    check("ifid_pc", id_pc, e.pc);
                    check("ifid_inst", id_inst, e.inst);
                end
            end
            prev_stall = stall;
            if (req_w) begin
                n_req_w++;
                if (exp_req_w.size() != 0) check("wrap_req_addr", addr_w, exp_req_w.pop_front());
            end
        end
    end

    // Directed script; each step() enters the next cycle, checks sit at the falling edge.
    initial begin
        n_chk       = 0;
        n_fail      = 0;
        n_req_w     = 0;
        lat         = 1;
        rst         = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;

        exp_req = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h100, 32'h104, 32'h200, 32'h204,
                    32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h0, 32'h4};
        exp_ifid.push_back('{32'h0, 32'h0});
        exp_ifid.push_back('{32'h4, 32'h4});
        exp_ifid.push_back('{32'h8, 32'h8});
        exp_ifid.push_back('{32'h100, 32'h100});
        exp_ifid.push_back('{32'h200, 32'h200});
        exp_ifid.push_back('{32'hFFFF_FFF8, 32'hFFFF_FFF8});
        exp_ifid.push_back('{32'hFFFF_FFFC, 32'hFFFF_FFFC});
        exp_ifid.push_back('{32'h0, 32'h0});
        exp_req_w = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0};

        // reset state
        repeat (3) step();
        @(negedge clk);
        check("rst_valid", {31'b0, id_valid}, 32'h0);
        check("rst_pc", id_pc, 32'h0);
        check("rst_inst", id_inst, 32'h13);
        check("rst_req", {31'b0, imem_req}, 32'h0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_addr_w", addr_w, 32'hFFFF_FFF8);

        // 1: streaming with 1-cycle memory
        step(); rst = 1'b0;                 // A   req 0
        step();                             // A+1
        step();                             // A+2 IF/ID (0,0), req 4
        step();                             // A+3
        // 2: stall over the arrival of the 0x8 response
        step(); stall = 1'b1;               // A+4 IF/ID (4,4), req 8
        step();                             // A+5 response arrives -> HOLD
        @(negedge clk);
        check("stall_valid", {31'b0, id_valid}, 32'h1);
        check("stall_pc", id_pc, 32'h4);
        check("stall_inst", id_inst, 32'h4);
        step();                             // A+6
        @(negedge clk);
        check("hold_pc", id_pc, 32'h4);
        check("hold_req", {31'b0, imem_req}, 32'h0);
        step(); stall = 1'b0;               // A+7 release
        @(negedge clk);
        check("release_pc", id_pc, 32'h4);
        check("release_req", {31'b0, imem_req}, 32'h0);
        // 3: latency 3, redirect while 0xC is in flight
        step(); lat = 3;                    // A+8 IF/ID (8,8), req C
        step(); redirect = 1'b1; redirect_pc = 32'h100; // A+9
        step(); redirect = 1'b0;            // A+10 KILL
        @(negedge clk);
        check("kill_valid", {31'b0, id_valid}, 32'h0);
        check("kill_addr", imem_addr, 32'h100);
        check("kill_req", {31'b0, imem_req}, 32'h0);
        step();                             // A+11 stale 0xC data discarded
        @(negedge clk);
        check("discard_req", {31'b0, imem_req}, 32'h0);
        check("discard_valid", {31'b0, id_valid}, 32'h0);
        step();                             // A+12 req 0x100
        repeat (3) step();                  // A+13..A+15
        // 4: stall and redirect together
        step(); stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h203; // A+16
        step(); stall = 1'b0; redirect = 1'b0; lat = 1;               // A+17
        @(negedge clk);
        check("flush_valid", {31'b0, id_valid}, 32'h0);
        check("flush_inst", id_inst, 32'h13);
        check("flush_pc", id_pc, 32'h100);
        check("flush_addr", imem_addr, 32'h200);
        repeat (4) step();                  // A+18..A+21
        // 5: wrap through the top of the address space
        step(); redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;         // A+22
        step(); redirect = 1'b0;            // A+23
        repeat (4) step();                  // A+24..A+27
        // 6: reset pulse while waiting on a slow response
        step(); lat = 3;                    // A+28 req 0 after wrap
        step(); rst = 1'b1;                 // A+29 WAIT
        @(negedge clk);
        check("midrst_req", {31'b0, imem_req}, 32'h0);
        check("pre_rst_pc", id_pc, 32'hFFFF_FFFC);
        step(); rst = 1'b0; lat = 1;        // A+30
        @(negedge clk);
        check("post_rst_valid", {31'b0, id_valid}, 32'h0);
        check("post_rst_pc", id_pc, 32'h0);
        check("post_rst_inst", id_inst, 32'h13);
        check("post_rst_addr", imem_addr, 32'h0);
        step();                             // A+31
        step();                             // A+32 IF/ID (0,0), req 4
        @(negedge clk);
        #1;

        check("req_queue_left", exp_req.size(), 32'd0);
        check("ifid_queue_left", exp_ifid.size(), 32'd0);
        check("wrap_queue_left", exp_req_w.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
